// File: rtl/imem_pkg.sv
// Shared types and constants for the loadable instruction memory.
package imem_pkg;

   // Boot loads the array; run serves fetches.
   typedef enum logic {
      BOOT,
      RUN
   } imem_state_e;

   // MOV R0,R0 -- returned for any fetch that cannot produce real data.
   localparam logic [31:0] IMEM_NOP = 32'hE1A00000;

   // Word-index width for a power-of-2 depth.
   function automatic int unsigned imem_idx_w(input int unsigned depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: synchronous write, registered read gated by the read enable.
// The array has no reset; rdata holds its value while re is low.
module imem_array #(
   parameter int unsigned WORD_W = 32,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned IDX_W  = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic              re,
   input  logic [IDX_W-1:0]  raddr,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH];

   // Write port, used only while booting.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Registered read; holding on re=0 keeps the last fetched word stable.
   always_ff @(posedge clk) begin
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/imem_sync_loadable.sv
// Boot-loadable instruction memory for the IF stage.
// Loads over a streaming port in BOOT, then serves 1-cycle-latency fetches in RUN,
// honouring stall and flush. Invalid fetches return DEFAULT_INSTR with addr_fault.
// Optional: define IMEM_PARITY_EN to store an even-parity bit per word and add the
// sticky parity_err output.
module imem_sync_loadable
   import imem_pkg::*;
#(
   parameter int unsigned        DATA_W        = 32,
   parameter int unsigned        DEPTH         = 256,
   parameter int unsigned        ADDR_W        = 32,
   parameter logic [DATA_W-1:0]  DEFAULT_INSTR = DATA_W'(IMEM_NOP)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic              boot_done,
   input  logic              fetch_valid,
   input  logic [ADDR_W-1:0] fetch_addr,
   input  logic              stall,
   input  logic              flush,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_addr,
`ifdef IMEM_PARITY_EN
   output logic              parity_err,
`endif
   output logic              addr_fault
);

   localparam int unsigned IDX_W = imem_idx_w(DEPTH);
   localparam int unsigned CNT_W = IDX_W + 1;
`ifdef IMEM_PARITY_EN
   localparam int unsigned WORD_W = DATA_W + 1;
`else
   localparam int unsigned WORD_W = DATA_W;
`endif

   imem_state_e       state_q;
   logic [IDX_W-1:0]  load_ptr_q;
   logic [CNT_W-1:0]  loaded_cnt_q;
   logic              valid_q;
   logic [ADDR_W-1:0] addr_q;
   logic              fault_q;
   // use_mem_q: instr comes from the array rather than DEFAULT_INSTR.
   // chk_q: the held result is a real array read whose parity must be checked.
   logic              use_mem_q;
   logic              chk_q;

   logic              load_acc;
   logic              load_end;
   logic              accept;
   logic              fault_now;
   logic [ADDR_W-1:0] word_idx;
   logic [IDX_W-1:0]  rd_idx;
   logic [WORD_W-1:0] wr_word;
   logic [WORD_W-1:0] rd_word;
   logic              par_bad;

   // Load and fetch qualification; fault uses the full word index so nothing wraps.
   always_comb begin
      load_acc  = (state_q == BOOT) && load_valid;
      load_end  = load_last || (load_ptr_q == IDX_W'(DEPTH - 1));
      accept    = (state_q == RUN) && fetch_valid && !stall && !flush;
      word_idx  = fetch_addr >> 2;
      rd_idx    = fetch_addr[IDX_W+1:2];
      fault_now = (fetch_addr[1:0] != 2'b00) || (word_idx >= ADDR_W'(loaded_cnt_q));
   end

   // Stored word, with the parity bit appended when enabled.
   always_comb begin
`ifdef IMEM_PARITY_EN
      wr_word = {^load_data, load_data};
      par_bad = use_mem_q && (^rd_word);
`else
      wr_word = load_data;
      par_bad = 1'b0;
`endif
   end

   imem_array #(
      .WORD_W (WORD_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk   (clk),
      .we    (load_acc),
      .waddr (load_ptr_q),
      .wdata (wr_word),
      .re    (accept && !fault_now),
      .raddr (rd_idx),
      .rdata (rd_word)
   );

   // FSM, load counters and fetch result registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= BOOT;
         load_ptr_q   <= '0;
         loaded_cnt_q <= '0;
         valid_q      <= 1'b0;
         addr_q       <= '0;
         fault_q      <= 1'b0;
         use_mem_q    <= 1'b0;
         chk_q        <= 1'b0;
      end else begin
         if (load_acc) begin
            load_ptr_q   <= load_ptr_q + 1'b1;
            loaded_cnt_q <= loaded_cnt_q + 1'b1;
            if (load_end) begin
               state_q <= RUN;
            end
         end

         if (flush) begin
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            chk_q   <= 1'b0;
         end else if (accept) begin
            valid_q   <= 1'b1;
            addr_q    <= fetch_addr;
            fault_q   <= fault_now;
            use_mem_q <= !fault_now;
            chk_q     <= !fault_now;
         end else if (!stall) begin
            valid_q <= 1'b0;
         end
      end
   end

`ifdef IMEM_PARITY_EN
   logic parity_err_q;

   // Sticky record of any parity mismatch seen on a fetched word.
   always_ff @(posedge clk) begin
      if (!rst) begin
         parity_err_q <= 1'b0;
      end else if (chk_q && par_bad) begin
         parity_err_q <= 1'b1;
      end
   end

   assign parity_err = parity_err_q;
`endif

   // Outputs; a parity-bad word is replaced by the NOP and reported as a fault.
   always_comb begin
      load_ready  = (state_q == BOOT);
      boot_done   = (state_q == RUN);
      instr_valid = valid_q;
      instr_addr  = addr_q;
      instr       = (use_mem_q && !par_bad) ? rd_word[DATA_W-1:0] : DEFAULT_INSTR;
      addr_fault  = fault_q || (chk_q && par_bad);
   end

endmodule

// File: tb/tb_imem_sync_loadable.sv
// Directed self-checking bench for imem_sync_loadable (DEPTH=4).
module tb_imem_sync_loadable;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 32;
   localparam logic [31:0] NOP    = 32'hE1A00000;

   logic              clk;
   logic              rst;
   logic              load_valid;
   logic [DATA_W-1:0] load_data;
   logic              load_last;
   logic              load_ready;
   logic              boot_done;
   logic              fetch_valid;
   logic [ADDR_W-1:0] fetch_addr;
   logic              stall;
   logic              flush;
   logic              instr_valid;
   logic [DATA_W-1:0] instr;
   logic [ADDR_W-1:0] instr_addr;
   logic              addr_fault;
`ifdef IMEM_PARITY_EN
   logic              parity_err;
`endif

   int n_checks;
   int n_errors;

   logic [31:0] w [3];
   logic [31:0] a [4];

   imem_sync_loadable #(
      .DATA_W (DATA_W),
      .DEPTH  (4),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .load_last   (load_last),
      .load_ready  (load_ready),
      .boot_done   (boot_done),
      .fetch_valid (fetch_valid),
      .fetch_addr  (fetch_addr),
      .stall       (stall),
      .flush       (flush),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_addr  (instr_addr),
`ifdef IMEM_PARITY_EN
      .parity_err  (parity_err),
`endif
      .addr_fault  (addr_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge; outputs are sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] addr);
      fetch_valid = 1'b1;
      fetch_addr  = addr;
      step();
      fetch_valid = 1'b0;
   endtask

   task automatic expect_out(input string tag, input logic v, input logic [31:0] d,
                             input logic [31:0] ad, input logic f);
      check({tag, ".valid"}, 64'(instr_valid), 64'(v));
      check({tag, ".instr"}, 64'(instr), 64'(d));
      check({tag, ".addr"},  64'(instr_addr), 64'(ad));
      check({tag, ".fault"}, 64'(addr_fault), 64'(f));
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      w[0] = 32'hE3A00014; w[1] = 32'hE3A01A01; w[2] = 32'hE3A02103;
      a[0] = 32'h11111111; a[1] = 32'h22222222; a[2] = 32'h33333333; a[3] = 32'h44444444;
      rst = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
      fetch_valid = 1'b0; fetch_addr = '0; stall = 1'b0; flush = 1'b0;
      step();
      step();
      rst = 1'b1;

      // Reset state
      check("rst.boot_done", 64'(boot_done), 64'd0);
      check("rst.load_ready", 64'(load_ready), 64'd1);
      expect_out("rst", 1'b0, NOP, 32'h0, 1'b0);

      // Boot: 3 words, fetch requests ignored while booting
      fetch_valid = 1'b1;
      fetch_addr  = 32'h0;
      for (int i = 0; i < 3; i++) begin
         load_valid = 1'b1;
         load_data  = w[i];
         load_last  = (i == 2);
         step();
         check("boot.ign_valid", 64'(instr_valid), 64'd0);
         check("boot.done", 64'(boot_done), 64'(i == 2));
      end
      load_valid = 1'b0; load_last = 1'b0; fetch_valid = 1'b0;
      check("boot.load_ready", 64'(load_ready), 64'd0);

      // Loads in RUN are ignored: slot 3 stays unloaded
      load_valid = 1'b1; load_data = 32'hDEADBEEF;
      step();
      load_valid = 1'b0;

      // Back-to-back fetches
      fetch(32'h0); expect_out("seq0", 1'b1, w[0], 32'h0, 1'b0);
      fetch(32'h4); expect_out("seq1", 1'b1, w[1], 32'h4, 1'b0);
      fetch(32'h8); expect_out("seq2", 1'b1, w[2], 32'h8, 1'b0);
      step();       expect_out("idle", 1'b0, w[2], 32'h8, 1'b0);

      // Out of range and misaligned
      fetch(32'hC); expect_out("oor", 1'b1, NOP, 32'hC, 1'b1);
      fetch(32'h6); expect_out("mis", 1'b1, NOP, 32'h6, 1'b1);

      // Stall hold
      fetch(32'h4); expect_out("st0", 1'b1, w[1], 32'h4, 1'b0);
      fetch_valid = 1'b1; fetch_addr = 32'h8; stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         expect_out("stall", 1'b1, w[1], 32'h4, 1'b0);
      end
      stall = 1'b0;
      step();
      fetch_valid = 1'b0;
      expect_out("unstall", 1'b1, w[2], 32'h8, 1'b0);

      // Flush clears a held fault and beats stall + fetch
      fetch(32'hC); expect_out("pre_fl", 1'b1, NOP, 32'hC, 1'b1);
      fetch_valid = 1'b1; fetch_addr = 32'h0; stall = 1'b1; flush = 1'b1;
      step();
      fetch_valid = 1'b0; stall = 1'b0; flush = 1'b0;
      check("flush.valid", 64'(instr_valid), 64'd0);
      check("flush.fault", 64'(addr_fault), 64'd0);
      check("flush.addr", 64'(instr_addr), 64'hC);
      step();
      check("flush.dropped", 64'(instr_valid), 64'd0);
      check("flush.addr2", 64'(instr_addr), 64'hC);

      // Reset mid-load
      rst = 1'b0; step(); rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         load_valid = 1'b1;
         load_data  = 32'hAAAA0000 + 32'(i);
         step();
      end
      load_valid = 1'b0;
      rst = 1'b0; step(); rst = 1'b1;
      check("rst2.boot_done", 64'(boot_done), 64'd0);
      check("rst2.load_ready", 64'(load_ready), 64'd1);
      expect_out("rst2", 1'b0, NOP, 32'h0, 1'b0);

      // Auto-transition after DEPTH words without load_last
      for (int i = 0; i < 4; i++) begin
         load_valid = 1'b1;
         load_data  = a[i];
         step();
         check("auto.done", 64'(boot_done), 64'(i == 3));
      end
      load_valid = 1'b0;
      fetch(32'h10); expect_out("auto.oor", 1'b1, NOP, 32'h10, 1'b1);
      fetch(32'hC);  expect_out("auto.w3", 1'b1, a[3], 32'hC, 1'b0);
      fetch(32'h0);  expect_out("auto.w0", 1'b1, a[0], 32'h0, 1'b0);

`ifdef IMEM_PARITY_EN
      // Parity: corrupt word 1 then fetch it
      check("par.init", 64'(parity_err), 64'd0);
      dut.u_array.mem[1][0] = ~dut.u_array.mem[1][0];
      fetch(32'h4); expect_out("par", 1'b1, NOP, 32'h4, 1'b1);
      step();
      check("par.err", 64'(parity_err), 64'd1);
      fetch(32'h0); expect_out("par.ok", 1'b1, a[0], 32'h0, 1'b0);
      step();
      check("par.sticky", 64'(parity_err), 64'd1);
      rst = 1'b0; step(); rst = 1'b1;
      check("par.rst", 64'(parity_err), 64'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
